// File: rtl/ext_arbiter.sv
// Round-robin arbiter that shares one 16-bit immediate extender between two requesters,
// registering the extender operands and returning the tagged result one cycle later.
module ext_arbiter #(
    parameter bit RESET_PRIO = 1'b0,
    localparam int unsigned IN_W  = 11,
    localparam int unsigned SEL_W = 2,
    localparam int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0,
    input  logic [IN_W-1:0]  req0_in,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req0_sign,
    input  logic             req1,
    input  logic [IN_W-1:0]  req1_in,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic             req1_sign,
    output logic             gnt0,
    output logic             gnt1,
    output logic [IN_W-1:0]  ext_in,
    output logic [SEL_W-1:0] ext_sel,
    output logic             ext_sign,
    input  logic [OUT_W-1:0] ext_out,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [OUT_W-1:0] resp_imm,
    output logic             resp_err,
    output logic             busy
);

    typedef struct packed {
        logic [IN_W-1:0]  val;
        logic [SEL_W-1:0] sel;
        logic             sign;
    } op_t;

    localparam logic [SEL_W-1:0] SEL_ILLEGAL = SEL_W'(3);

    op_t  op0_c;
    op_t  op1_c;
    op_t  win_c;
    logic gnt_any_c;
    logic resp_load_c;
    logic last;
    logic iss_valid;
    logic iss_id;

    assign op0_c = {req0_in, req0_sel, req0_sign};
    assign op1_c = {req1_in, req1_sel, req1_sign};

    // Arbitration: sole requester wins; on contention the one not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !flush) begin
            if (req0 && req1) begin
                if (last) gnt0 = 1'b1;
                else      gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign gnt_any_c   = gnt0 | gnt1;
    assign win_c       = gnt1 ? op1_c : op0_c;
    assign resp_load_c = iss_valid && !flush;

    // Issue and response stages; flush drops in-flight work but keeps data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= ~RESET_PRIO;
            iss_valid  <= 1'b0;
            iss_id     <= 1'b0;
            ext_in     <= '0;
            ext_sel    <= '0;
            ext_sign   <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_imm   <= '0;
            resp_err   <= 1'b0;
        end else begin
            iss_valid  <= gnt_any_c;
            resp_valid <= resp_load_c;
            if (flush) begin
                last <= ~RESET_PRIO;
            end else if (gnt_any_c) begin
                last <= gnt1;
            end
            if (gnt_any_c) begin
                ext_in   <= win_c.val;
                ext_sel  <= win_c.sel;
                ext_sign <= win_c.sign;
                iss_id   <= gnt1;
            end
            if (resp_load_c) begin
                resp_id  <= iss_id;
                resp_err <= (ext_sel == SEL_ILLEGAL);
                resp_imm <= (ext_sel == SEL_ILLEGAL) ? '0 : ext_out;
            end
        end
    end

    assign busy = iss_valid;

endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit immediate extender (`extend_16bit`). Decode and branch-target logic both need immediates extended. This block serialises their requests onto one extender instance, registers the operands that drive the extender, and returns the tagged 16-bit result one cycle later. It sits in the decode stage, with the extender instantiated beside it by the parent.

## Interface
- `RESET_PRIO`, default 0: requester that wins the first contended cycle after reset or flush (0 or 1).
- `clk` input 1: the single clock for the block.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous pipeline flush; discards in-flight work.
- `req0`, `req1` input 1 each: request valid from requester 0 and requester 1.
- `req0_in`, `req1_in` input 11 each: raw immediate field.
- `req0_sel`, `req1_sel` input 2 each: width select; 00 = 5-bit, 01 = 8-bit, 10 = 11-bit, 11 = illegal.
- `req0_sign`, `req1_sign` input 1 each: 1 = sign-extend, 0 = zero-extend.
- `gnt0`, `gnt1` output 1 each: combinational grant. The request is accepted in the cycle its grant is high.
- `ext_in` output 11, `ext_sel` output 2, `ext_sign` output 1: registered operands, wired to the extender's `in`, `sel` and `sign_ext`.
- `ext_out` input 16: extender result; the extender is purely combinational.
- `resp_valid` output 1: one-cycle pulse marking a result.
- `resp_id` output 1: requester that owns the result.
- `resp_imm` output 16: extended immediate.
- `resp_err` output 1: the request carried illegal sel 11.
- `busy` output 1: the issue register holds a valid operation.

## Operation
- Requester protocol:
  - A requester holds `reqN` and its payload stable until it sees `gntN` high.
  - Dropping a request before it is granted is allowed.
  - At most one grant is high per cycle.
  - No grant is issued while `rst` or `flush` is high.
- Arbitration:
  - If only one request is high, that requester is granted.
  - If both are high, the requester that is not `last` is granted.
  - `last` is a 1-bit register that is set to the granted ID on every grant.
  - Reset and flush set `last` to the complement of `RESET_PRIO`.
- Issue stage, on a grant:
  - The winning payload is loaded into the `ext_in`/`ext_sel`/`ext_sign` registers.
  - The ID is loaded into an issue-ID register, and the issue-valid bit is set.
  - Without a grant, the issue-valid bit clears.
  - The operand registers hold their previous value when there is no grant (no toggling).
- Response stage, when issue-valid is set:
  - The next edge loads `resp_imm` from `ext_out`, `resp_id` from the issue ID, and sets `resp_valid` to 1.
  - Otherwise `resp_valid` is 0; `resp_imm` and `resp_id` hold their last value.
- Illegal select: an issued sel = 11 still completes. The response has `resp_err` = 1 and `resp_imm` forced to 16'h0000, regardless of `ext_out`.
- Pipelining: the block is fully pipelined, one grant per cycle. A new grant in cycle N+1 overlaps the response of the cycle-N grant.
- `busy` equals issue-valid.

## Timing
- Latency:
  - Request granted in cycle N.
  - Operands appear on `ext_*` after edge N, and the extender resolves during cycle N+1.
  - `resp_valid` is high in cycle N+2, i.e. after edge N+1.
  - Request-to-response is 2 cycles.
- Throughput: 1 response per cycle with continuous requests.
- With both requesters held continuously, grants alternate every cycle: 0,1,0,1 when `RESET_PRIO` = 0.
- Reset (`rst` high at an edge) clears:
  - `gnt0`, `gnt1` (forced 0 combinationally while `rst` is high);
  - `ext_in`, `ext_sel`, `ext_sign`;
  - issue-valid, `busy`;
  - `resp_valid`, `resp_id`, `resp_err`, `resp_imm` (to 16'h0000);
  - `last` is set to the complement of `RESET_PRIO`.
- Flush (`flush` high at an edge):
  - Clears issue-valid and `resp_valid` and resets `last`.
  - The operation issued in the previous cycle produces no response.
  - Operand and response data registers are not cleared.
  - `rst` takes priority over `flush`.
- Reset or flush mid-operation: any request accepted before the event is lost. The requester must re-request, because the granted payload was already consumed.
- A request arriving in the same cycle that `flush` deasserts is arbitrated normally.

## Test plan
- Single request: `req0`=1 with in=11'h7FF, sel=00, sign=1.
  - `gnt0` is high the same cycle.
  - `resp_valid`=1, `resp_id`=0, `resp_imm`=16'hFFFF two cycles later.
- Width/sign sweep on requester 1, in=11'h7FF:
  - sel=01, sign=0 → 16'h00FF.
  - sel=10, sign=1 → 16'hFFFF.
  - in=11'b10101011011, sel=10, sign=1 → 16'hFD5B.
  - same input with sign=0 → 16'h055B.
- Contention: both requesters held for 4 cycles with distinct payloads.
  - Grants come out 0,1,0,1.
  - Responses are back-to-back with `resp_id` 0,1,0,1 and each `resp_imm` matches its own payload.
- Illegal select: `req0` with sel=11, in=11'h123 → `resp_err`=1, `resp_imm`=16'h0000, `resp_valid` pulses once.
- Flush: grant in cycle N, then `flush`=1 in cycle N+1 → no `resp_valid` in cycle N+2. The next contended grant goes to `RESET_PRIO`.
- Reset mid-stream: continuous requests with `rst` asserted for 2 cycles.
  - All outputs read zero during reset and no grants are issued.
  - Operation resumes the cycle `rst` falls, with requester 0 granted first.
